// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_ctrl_pkg;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  typedef enum logic [1:0] {
    RUN          = 2'd0,
    DIV_BUSY     = 2'd1,
    DIV_COMPLETE = 2'd2
  } ctrl_state_e;
endpackage

// File: rtl/hazard_perf_counters.sv
// Three saturating event counters (load-use bubbles, divider stall cycles, redirects).
module hazard_perf_counters #(
  parameter int PERF_W = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [2:0]             inc,
  output logic [2:0][PERF_W-1:0] cnt
);
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (inc[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + PERF_W'(1);
    end
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for IF/ID, ID/EX, EX/MEM plus divider-wait FSM.
// Optional perf counters under HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DIV_TIMEOUT = 64,
  parameter int PERF_W      = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [REG_ADDR_W-1:0] ID_RS1,
  input  logic [REG_ADDR_W-1:0] ID_RS2,
  input  logic                  ID_USES_RS1,
  input  logic                  ID_USES_RS2,
  input  logic [REG_ADDR_W-1:0] EX_RD,
  input  logic                  EX_MEM_READ,
  input  logic                  EX_IS_DIV,
  input  logic                  DIV_DONE,
  input  logic                  EX_REDIRECT,
  output logic                  PC_STALL,
  output logic                  IF_ID_STALL,
  output logic                  IF_ID_FLUSH,
  output logic                  ID_EX_STALL,
  output logic                  ID_EX_FLUSH,
  output logic                  EX_MEM_FLUSH,
  output logic                  DIV_START,
  output logic                  DIV_TIMEOUT_ERR,
  output logic [1:0]            CTRL_STATE
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]     PERF_LOADUSE_CNT,
  output logic [PERF_W-1:0]     PERF_DIV_STALL_CNT,
  output logic [PERF_W-1:0]     PERF_FLUSH_CNT
`endif
);
  localparam int CNT_W = (DIV_TIMEOUT > 2) ? $clog2(DIV_TIMEOUT) : 1;

  if (DIV_TIMEOUT < 2 || PERF_W < 1) begin : g_bad_params
    $error("pipeline_hazard_ctrl: DIV_TIMEOUT must be >= 2 and PERF_W >= 1");
  end

  ctrl_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic start_d, err_set, load_use, timeout;

  assign load_use = EX_MEM_READ && (EX_RD != X0) &&
                    ((ID_USES_RS1 && (ID_RS1 == EX_RD)) ||
                     (ID_USES_RS2 && (ID_RS2 == EX_RD)));
  assign timeout  = (cnt_q == CNT_W'(DIV_TIMEOUT - 1));
  assign CTRL_STATE = state_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    start_d      = 1'b0;
    err_set      = 1'b0;
    PC_STALL     = 1'b0;
    IF_ID_STALL  = 1'b0;
    IF_ID_FLUSH  = 1'b0;
    ID_EX_STALL  = 1'b0;
    ID_EX_FLUSH  = 1'b0;
    EX_MEM_FLUSH = 1'b0;
    case (state_q)
      RUN, DIV_COMPLETE: begin
        // EX_IS_DIV in DIV_COMPLETE is the divide that just finished, so only RUN may start one.
        if (EX_REDIRECT) begin
          IF_ID_FLUSH = 1'b1;
          ID_EX_FLUSH = 1'b1;
        end else if (state_q == RUN && EX_IS_DIV) begin
          PC_STALL     = 1'b1;
          IF_ID_STALL  = 1'b1;
          ID_EX_STALL  = 1'b1;
          EX_MEM_FLUSH = 1'b1;
          start_d      = 1'b1;
          state_d      = DIV_BUSY;
        end else if (load_use) begin
          PC_STALL    = 1'b1;
          IF_ID_STALL = 1'b1;
          ID_EX_FLUSH = 1'b1;
        end
        if (state_q == DIV_COMPLETE) state_d = RUN;
      end
      DIV_BUSY: begin
        PC_STALL     = 1'b1;
        IF_ID_STALL  = 1'b1;
        ID_EX_STALL  = 1'b1;
        EX_MEM_FLUSH = 1'b1;
        cnt_d        = cnt_q + CNT_W'(1);
        if (DIV_DONE || timeout) begin
          state_d = DIV_COMPLETE;
          cnt_d   = '0;
          err_set = !DIV_DONE;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q         <= RUN;
      cnt_q           <= '0;
      DIV_START       <= 1'b0;
      DIV_TIMEOUT_ERR <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      DIV_START <= start_d;
      if (err_set) DIV_TIMEOUT_ERR <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [2:0][PERF_W-1:0] perf_cnt;

  // Load-use bubble is the only case with PC_STALL and ID_EX_FLUSH together.
  hazard_perf_counters #(.PERF_W(PERF_W)) u_perf (
    .CLK (CLK),
    .RST (RST),
    .inc ({IF_ID_FLUSH, state_q == DIV_BUSY, PC_STALL & ID_EX_FLUSH}),
    .cnt (perf_cnt)
  );

  assign PERF_LOADUSE_CNT   = perf_cnt[0];
  assign PERF_DIV_STALL_CNT = perf_cnt[1];
  assign PERF_FLUSH_CNT     = perf_cnt[2];
`endif
endmodule
